// File: rtl/load_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lb_pkg / load_buffer_if                                                    |
// | Packet types and bus bundle for the load buffer.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef XLEN
`define XLEN 32
`endif

package lb_pkg;
    localparam int XLEN      = `XLEN;
    localparam int ROB_TAG_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      address;
        logic [2:0]           funct3;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [31:0]          inst;
        logic [XLEN-1:0]      npc;
    } lb_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      value;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [31:0]          inst;
        logic [XLEN-1:0]      npc;
    } ex_wr_packet_t;
endpackage

interface load_buffer_if;
    import lb_pkg::*;

    lb_packet_t      lb_packet_in;
    logic            squash;
    logic            lb_full;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rdata_valid;
    logic [XLEN-1:0] mem_rdata;
    ex_wr_packet_t   lb_wr_packet;
    logic            cdb_gnt;

    modport slave (
        input  lb_packet_in, squash, mem_gnt, mem_rdata_valid, mem_rdata, cdb_gnt,
        output lb_full, mem_req, mem_addr, lb_wr_packet
    );

    modport master (
        output lb_packet_in, squash, mem_gnt, mem_rdata_valid, mem_rdata, cdb_gnt,
        input  lb_full, mem_req, mem_addr, lb_wr_packet
    );
endinterface

`default_nettype wire

// File: rtl/load_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_buffer                                                                |
// | In-order load FIFO issuing one load at a time to data memory, with         |
// | byte/half extraction and CDB writeback.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_buffer
    import lb_pkg::*;
#(
    parameter int LB_SIZE = 4
) (
    input  wire logic    clock,
    input  wire logic    reset,
    load_buffer_if.slave lb
);
    localparam int               PTR_W      = $clog2(LB_SIZE);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LB_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           state_q, state_d;
    lb_packet_t       fifo_q [LB_SIZE];
    lb_packet_t       fifo_d [LB_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    lb_packet_t       entry_q, entry_d;
    ex_wr_packet_t    wr_q, wr_d;
    logic             enq;
    logic             deq;

    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0] word,
        input logic [1:0]      ofs,
        input logic [2:0]      f3
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (ofs)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = ofs[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // lb_full looks only at the registered count, so a slot freed this cycle opens next cycle
    assign lb.lb_full      = (count_q == FULL_COUNT);
    assign enq             = lb.lb_packet_in.valid & ~lb.lb_full & ~lb.squash;
    assign deq             = (state_q == S_IDLE) & (count_q != '0) & ~lb.squash;
    assign lb.mem_req      = (state_q == S_REQ);
    assign lb.mem_addr     = {entry_q.address[XLEN-1:2], 2'b00};
    assign lb.lb_wr_packet = wr_q;

    always_comb begin
        fifo_d  = fifo_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (lb.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                fifo_d[tail_q] = lb.lb_packet_in;
                tail_d         = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (deq) begin
                    entry_d = fifo_q[head_q];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // a grant in the squash cycle still owes us a response, so it must be drained
                if (lb.mem_gnt) begin
                    state_d = lb.squash ? S_DRAIN : S_WAIT;
                end else if (lb.squash) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lb.mem_rdata_valid) begin
                    if (lb.squash) begin
                        state_d = S_IDLE;
                    end else begin
                        wr_d.valid   = entry_q.valid;
                        wr_d.value   = extract(lb.mem_rdata, entry_q.address[1:0], entry_q.funct3);
                        wr_d.rob_tag = entry_q.rob_tag;
                        wr_d.inst    = entry_q.inst;
                        wr_d.npc     = entry_q.npc;
                        state_d      = S_WB;
                    end
                end else if (lb.squash) begin
                    state_d = S_DRAIN;
                end
            end
            S_WB: begin
                if (lb.squash || lb.cdb_gnt) begin
                    wr_d.valid = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (lb.mem_rdata_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            entry_q <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
            wr_q    <= wr_d;
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers and count
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

endmodule

`default_nettype wire
